// File: rtl/act_slot_scheduler_if.sv
// act_slot_scheduler_if: request, tFAW-block and issued-command bundle for act_slot_scheduler.
// master: bank-machine / tracker side (drives requests and faw_block).
// slave: the scheduler.
// Ports:
//   i_req_valid/i_req_rnk/i_req_bank/o_req_ready  request handshake.
//   i_faw_block                                    packed per-rank tFAW wait.
//   o_cmd0_* / o_cmd1_*                            sub-slot 0/1 command.
//   o_fifo_count                                   occupancy.
//   o_stall_cnt                                    present only with ACT_STALL_CNT_EN.
// Command encodings normally come from global.svh; the guarded fallbacks keep this bundle standalone.
`ifndef ACT
`define ACT 3'b011
`endif
`ifndef NOP
`define NOP 3'b111
`endif

interface act_slot_scheduler_if #(
  parameter int CMD_TYPE_WIDTH = 3,
  parameter int RNK_SEL_WIDTH  = 1,
  parameter int NUM_RNK        = 2**RNK_SEL_WIDTH,
  parameter int BANK_WIDTH     = 4,
  parameter int TIME_WIDTH     = 6,
  parameter int FIFO_DEPTH     = 4
);
  logic                              i_req_valid;
  logic [RNK_SEL_WIDTH-1:0]          i_req_rnk;
  logic [BANK_WIDTH-1:0]             i_req_bank;
  logic                              o_req_ready;
  logic [NUM_RNK*TIME_WIDTH-1:0]     i_faw_block;
  logic [CMD_TYPE_WIDTH-1:0]         o_cmd0_type;
  logic [RNK_SEL_WIDTH-1:0]          o_cmd0_rnk;
  logic [BANK_WIDTH-1:0]             o_cmd0_bank;
  logic [CMD_TYPE_WIDTH-1:0]         o_cmd1_type;
  logic [RNK_SEL_WIDTH-1:0]          o_cmd1_rnk;
  logic [BANK_WIDTH-1:0]             o_cmd1_bank;
  logic [$clog2(FIFO_DEPTH):0]       o_fifo_count;
`ifdef ACT_STALL_CNT_EN
  logic [15:0]                       o_stall_cnt;
`endif

  modport master (
    output i_req_valid, i_req_rnk, i_req_bank, i_faw_block,
    input  o_req_ready, o_cmd0_type, o_cmd0_rnk, o_cmd0_bank,
    input  o_cmd1_type, o_cmd1_rnk, o_cmd1_bank, o_fifo_count
`ifdef ACT_STALL_CNT_EN
    , input o_stall_cnt
`endif
  );

  modport slave (
    input  i_req_valid, i_req_rnk, i_req_bank, i_faw_block,
    output o_req_ready, o_cmd0_type, o_cmd0_rnk, o_cmd0_bank,
    output o_cmd1_type, o_cmd1_rnk, o_cmd1_bank, o_fifo_count
`ifdef ACT_STALL_CNT_EN
    , output o_stall_cnt
`endif
  );
endinterface

// File: rtl/act_slot_scheduler.sv
// Purpose: in-order ACT request FIFO placing up to two ACTs per i_clk into sub-slots 0 (offset 0) and 1 (offset 2).
// Latency: issue outputs are combinational from FIFO head, tRRD state and i_faw_block; a push is eligible next cycle.
// Backpressure: o_req_ready drops when the FIFO is full (registered count only); a blocked head stalls everything behind it.
// Ports:
//   i_clk, i_rstn        clock; synchronous active-low reset.
//   bus (slave modport)  request handshake, per-rank faw_block, two command sub-slots, fifo count.
// Optional: define ACT_STALL_CNT_EN to add the saturating 16-bit o_stall_cnt on the bus.
`ifndef ACT
`define ACT 3'b011
`endif
`ifndef NOP
`define NOP 3'b111
`endif

module act_slot_scheduler #(
  parameter int CMD_TYPE_WIDTH = 3,
  parameter int RNK_SEL_WIDTH  = 1,
  parameter int NUM_RNK        = 2**RNK_SEL_WIDTH,
  parameter int BANK_WIDTH     = 4,
  parameter int TIME_WIDTH     = 6,
  parameter int T_RRD          = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  act_slot_scheduler_if.slave bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int XW = TIME_WIDTH + 1;
  localparam logic [CMD_TYPE_WIDTH-1:0] CMD_ACT = CMD_TYPE_WIDTH'(`ACT);
  localparam logic [CMD_TYPE_WIDTH-1:0] CMD_NOP = CMD_TYPE_WIDTH'(`NOP);

  // Request storage
  logic [RNK_SEL_WIDTH-1:0] r_mem_rnk  [FIFO_DEPTH];
  logic [BANK_WIDTH-1:0]    r_mem_bank [FIFO_DEPTH];
  logic [PW-1:0]            r_rd_ptr;
  logic [PW-1:0]            r_wr_ptr;
  logic [CW-1:0]            r_count;

  // Remaining sub-cycles, measured from sub-slot 0 of the current cycle, until rank r is tRRD-legal
  logic [TIME_WIDTH-1:0]    r_rrd_rem [NUM_RNK];

  logic                     w_ready;
  logic                     w_push;
  logic [1:0]               w_pop;
  logic [PW-1:0]            w_rd_ptr1;
  logic                     w_h_vld;
  logic                     w_s_vld;
  logic [RNK_SEL_WIDTH-1:0] w_h_rnk;
  logic [BANK_WIDTH-1:0]    w_h_bank;
  logic [RNK_SEL_WIDTH-1:0] w_s_rnk;
  logic [BANK_WIDTH-1:0]    w_s_bank;
  logic [TIME_WIDTH-1:0]    w_faw [NUM_RNK];
  logic [NUM_RNK-1:0]       w_ok0;
  logic [NUM_RNK-1:0]       w_ok1;
  logic                     w_iss0;
  logic                     w_iss1;
  logic [RNK_SEL_WIDTH-1:0] w_iss1_rnk;
  logic [BANK_WIDTH-1:0]    w_iss1_bank;
  logic [XW-1:0]            w_rrd_base [NUM_RNK];
  logic [TIME_WIDTH-1:0]    w_rrd_nxt  [NUM_RNK];

  assign w_ready   = (r_count != CW'(FIFO_DEPTH));
  assign w_push    = bus.i_req_valid && w_ready;
  assign w_rd_ptr1 = r_rd_ptr + PW'(1);
  assign w_h_vld   = (r_count != '0);
  assign w_s_vld   = (r_count >= CW'(2));
  assign w_h_rnk   = r_mem_rnk[r_rd_ptr];
  assign w_h_bank  = r_mem_bank[r_rd_ptr];
  assign w_s_rnk   = r_mem_rnk[w_rd_ptr1];
  assign w_s_bank  = r_mem_bank[w_rd_ptr1];

  // Offset-0 needs both constraints already met; offset-2 tolerates up to 2 sub-cycles of wait.
  always_comb begin
    for (int r = 0; r < NUM_RNK; r++) begin
      w_faw[r] = bus.i_faw_block[r*TIME_WIDTH +: TIME_WIDTH];
      w_ok0[r] = (r_rrd_rem[r] == '0) && (w_faw[r] == '0);
      w_ok1[r] = (r_rrd_rem[r] <= TIME_WIDTH'(2)) && (w_faw[r] <= TIME_WIDTH'(2));
    end
  end

  // In-order placement: the second entry may only ride along when the head takes sub-slot 0,
  // and only on a different rank so a rank never sees two ACTs in one cycle.
  always_comb begin
    w_iss0      = 1'b0;
    w_iss1      = 1'b0;
    w_iss1_rnk  = w_h_rnk;
    w_iss1_bank = w_h_bank;
    w_pop       = 2'd0;
    if (i_rstn && w_h_vld) begin
      if (w_ok0[w_h_rnk]) begin
        w_iss0 = 1'b1;
        w_pop  = 2'd1;
        if (w_s_vld && (w_s_rnk != w_h_rnk) && w_ok1[w_s_rnk]) begin
          w_iss1      = 1'b1;
          w_iss1_rnk  = w_s_rnk;
          w_iss1_bank = w_s_bank;
          w_pop       = 2'd2;
        end
      end else if (w_ok1[w_h_rnk]) begin
        w_iss1 = 1'b1;
        w_pop  = 2'd1;
      end
    end
  end

  assign bus.o_req_ready  = w_ready;
  assign bus.o_fifo_count = r_count;
  assign bus.o_cmd0_type  = w_iss0 ? CMD_ACT : CMD_NOP;
  assign bus.o_cmd0_rnk   = w_iss0 ? w_h_rnk : '0;
  assign bus.o_cmd0_bank  = w_iss0 ? w_h_bank : '0;
  assign bus.o_cmd1_type  = w_iss1 ? CMD_ACT : CMD_NOP;
  assign bus.o_cmd1_rnk   = w_iss1 ? w_iss1_rnk : '0;
  assign bus.o_cmd1_bank  = w_iss1 ? w_iss1_bank : '0;

  // An ACT at offset o leaves T_RRD+o-4 for the next cycle; otherwise a cycle burns 4 sub-cycles.
  // Sum is one bit wider so T_RRD+2 cannot wrap before the saturating subtract.
  always_comb begin
    for (int r = 0; r < NUM_RNK; r++) begin
      if (w_iss0 && (w_h_rnk == RNK_SEL_WIDTH'(r))) begin
        w_rrd_base[r] = XW'(T_RRD);
      end else if (w_iss1 && (w_iss1_rnk == RNK_SEL_WIDTH'(r))) begin
        w_rrd_base[r] = XW'(T_RRD + 2);
      end else begin
        w_rrd_base[r] = {1'b0, r_rrd_rem[r]};
      end
      w_rrd_nxt[r] = (w_rrd_base[r] >= XW'(4)) ? TIME_WIDTH'(w_rrd_base[r] - XW'(4)) : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int r = 0; r < NUM_RNK; r++) begin
        r_rrd_rem[r] <= '0;
      end
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      r_rd_ptr <= r_rd_ptr + PW'(w_pop);
      r_count  <= r_count + CW'(w_push) - CW'(w_pop);
      for (int r = 0; r < NUM_RNK; r++) begin
        r_rrd_rem[r] <= w_rrd_nxt[r];
      end
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (i_rstn && w_push) begin
      r_mem_rnk[r_wr_ptr]  <= bus.i_req_rnk;
      r_mem_bank[r_wr_ptr] <= bus.i_req_bank;
    end
  end

`ifdef ACT_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_stall_cnt <= '0;
    end else if (w_h_vld && !w_iss0 && !w_iss1 && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.o_stall_cnt = r_stall_cnt;
`endif

endmodule
